// File: rtl/svc_rv_pipe_ctrl_chain.sv
// Valid/handshake controller for a DEPTH-deep register chain: per-stage advance,
// bubble and cascading flush controls, plus a registered occupancy count.
module svc_rv_pipe_ctrl_chain #(
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             ready_i,
    input  logic [DEPTH-1:0] stall_i,
    input  logic [DEPTH-1:0] flush_i,
    output logic [DEPTH-1:0] valid_o,
    output logic [DEPTH-1:0] advance_o,
    output logic [DEPTH-1:0] flush_o,
    output logic [DEPTH-1:0] bubble_o,
    output logic [CNT_W-1:0] count_o
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] can_accept;
    logic [DEPTH-1:0] flush_v;
    logic [DEPTH-1:0] in_valid;
    logic [DEPTH-1:0] advance_v;
    logic [DEPTH-1:0] bubble_v;
    logic             flush_run;
    logic             down_rdy;
    logic             accept_k;

    // Walk from the sink toward stage 0 so flush and readiness ripple backwards.
    always_comb begin
        flush_run  = 1'b0;
        down_rdy   = ready_i;
        accept_k   = 1'b0;
        flush_v    = '0;
        can_accept = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            flush_run     = flush_run | flush_i[k];
            flush_v[k]    = flush_run;
            accept_k      = !flush_run && (!valid_q[k] || (!stall_i[k] && down_rdy));
            can_accept[k] = accept_k;
            down_rdy      = accept_k;
        end
    end

    // Flush beats advance beats bubble; anything else holds the stage.
    always_comb begin
        in_valid    = '0;
        in_valid[0] = valid_i;
        for (int k = 1; k < DEPTH; k++) begin
            in_valid[k] = valid_q[k-1] && !stall_i[k-1];
        end
        advance_v = '0;
        bubble_v  = '0;
        valid_d   = valid_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush_v[k]) begin
                valid_d[k] = 1'b0;
            end else if (can_accept[k] && in_valid[k]) begin
                advance_v[k] = 1'b1;
                valid_d[k]   = 1'b1;
            end else if (can_accept[k]) begin
                bubble_v[k] = 1'b1;
                valid_d[k]  = 1'b0;
            end
        end
        count_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_d = count_d + CNT_W'(valid_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign ready_o   = can_accept[0];
    assign valid_o   = valid_q;
    assign count_o   = count_q;
    assign advance_o = advance_v;
    assign flush_o   = flush_v;
    assign bubble_o  = bubble_v;

endmodule
